// File: rtl/line_fill_pkg.sv
// Shared definitions for the line fill controller: FSM state encoding and
// default geometry of one assembled line.
// Imported by line_fill_ctrl and reg_file_single.
package line_fill_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_WORDS_PER_ENTRY = 16;

  // FILL: accepting source words; PAD: zero-filling the tail; FULL: line held for consumer.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } fill_state_e;

endpackage

// File: rtl/line_fill_ctrl_reg_file_single.sv
// Purpose: single-write-port register file exposing every entry in parallel.
// Latency: write visible on rdata_flat the cycle after the write edge; no reset on storage.
// Ports: clk, we/waddr/wdata write port, rdata_flat = all entries, entry 0 at the LSBs.
module reg_file_single
  import line_fill_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_WORDS_PER_ENTRY,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [DEPTH*DATA_WIDTH-1:0] rdata_flat
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign rdata_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

endmodule

// File: rtl/line_fill_ctrl.sv
// Purpose: packs a stream of words into one fixed-size line, zero-padding short lines.
// Latency: m_valid the cycle after the final accept (full line) or after the pad cycles (short line).
// Backpressure: s_ready is low in PAD and FULL; the line is held until m_valid && m_ready.
// Ports: clk, rst_n (async active-low); s_valid/s_ready/s_data/s_last word input;
//        m_valid/m_ready/m_data/m_word_count line output.
module line_fill_ctrl
  import line_fill_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int WORDS_PER_ENTRY = DEFAULT_WORDS_PER_ENTRY
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [DATA_WIDTH-1:0]                 s_data,
  input  logic                                  s_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [WORDS_PER_ENTRY*DATA_WIDTH-1:0] m_data,
  output logic [$clog2(WORDS_PER_ENTRY):0]      m_word_count
);

  localparam int IW = $clog2(WORDS_PER_ENTRY);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_ENTRY - 1);

  fill_state_e           state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         word_count;
  logic                  accept;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  // Both handshake flags come straight from state flops, so neither input
  // reaches the opposite-direction ready/valid combinationally.
  assign s_ready      = (state == FILL);
  assign m_valid      = (state == FULL);
  assign accept       = s_valid && s_ready;
  assign m_word_count = word_count;

  // PAD reuses the same write port to clear the tail, so a short line never
  // carries words left over from the previous line.
  assign wr_en   = accept || (state == PAD);
  assign wr_data = (state == PAD) ? '0 : s_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      idx        <= '0;
      word_count <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              // Index parks at the last slot; it is cleared only on handoff.
              state      <= FULL;
              word_count <= {1'b0, idx} + CW'(1);
            end else begin
              idx <= idx + IW'(1);
              if (s_last) begin
                state      <= PAD;
                word_count <= {1'b0, idx} + CW'(1);
              end
            end
          end
        end
        PAD: begin
          if (idx == LAST_IDX) begin
            state <= FULL;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        FULL: begin
          if (m_ready) begin
            state <= FILL;
            idx   <= '0;
          end
        end
        default: begin
          state <= FILL;
          idx   <= '0;
        end
      endcase
    end
  end

  reg_file_single #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (WORDS_PER_ENTRY),
    .AW         (IW)
  ) u_line_store (
    .clk        (clk),
    .we         (wr_en),
    .waddr      (idx),
    .wdata      (wr_data),
    .rdata_flat (m_data)
  );

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Self-checking bench for line_fill_ctrl (32-bit words, 16 words per line):
// directed line table, hold/reset sequences, then randomized traffic against
// a line-level reference model.
module tb_line_fill_ctrl;

  localparam int DW = 32;
  localparam int W  = 16;
  localparam int LW = DW * W;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic [LW-1:0] m_data;
  logic [CW-1:0] m_word_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          nwords;
    logic        last;
    logic [31:0] base;
    int          exp_count;
    int          exp_pad;
  } vec_t;

  always #5 clk = ~clk;

  line_fill_ctrl #(.DATA_WIDTH(DW), .WORDS_PER_ENTRY(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_word_count (m_word_count)
  );

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mk_line(input int n, input logic [DW-1:0] base);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < n; i++) l[i*DW +: DW] = base + DW'(i);
    return l;
  endfunction

  // Feed one line back-to-back, then wait for it to appear and check it.
  task automatic fill_line(input vec_t v);
    int extra;
    for (int i = 0; i < v.nwords; i++) begin
      s_valid = 1'b1;
      s_data  = v.base + DW'(i);
      s_last  = (i == v.nwords - 1) ? v.last : 1'b0;
      chk("s_ready_fill", s_ready, 1);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    extra   = 0;
    while (!m_valid && extra < 40) begin
      step();
      extra++;
    end
    chk("pad_cycles", extra, v.exp_pad);
    chk("m_valid_full", m_valid, 1);
    chk("count", m_word_count, v.exp_count);
    chk("line", m_data, mk_line(v.nwords, v.base));
    chk("s_ready_full", s_ready, 0);
  endtask

  task automatic release_line();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("m_valid_after_handoff", m_valid, 0);
    chk("s_ready_after_handoff", s_ready, 1);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    logic [LW-1:0] held;
    logic [LW-1:0] el;
    bit saw;
    logic [DW-1:0] cur[$];
    bit closed;
    int pad_left;
    int lines;
    int cyc;
    logic [DW-1:0] word;
    bit word_last;
    bit have_word;
    bit exp_valid;
    bit exp_ready;

    tbl[0] = '{nwords: 16, last: 1'b1, base: 32'h00, exp_count: 16, exp_pad: 0};
    tbl[1] = '{nwords: 5,  last: 1'b1, base: 32'hA0, exp_count: 5,  exp_pad: 11};
    tbl[2] = '{nwords: 16, last: 1'b0, base: 32'hD0, exp_count: 16, exp_pad: 0};
    tbl[3] = '{nwords: 1,  last: 1'b1, base: 32'hC0, exp_count: 1,  exp_pad: 15};
    tbl[4] = '{nwords: 15, last: 1'b1, base: 32'hE0, exp_count: 15, exp_pad: 1};
    tbl[5] = '{nwords: 2,  last: 1'b1, base: 32'hF0, exp_count: 2,  exp_pad: 14};

    // Reset state
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_count", m_word_count, 0);
    rst_n = 1'b1;
    step();

    // Directed line table
    for (int t = 0; t < 6; t++) begin
      fill_line(tbl[t]);
      release_line();
    end

    // Full line held under backpressure while new words are offered
    v = '{nwords: 16, last: 1'b1, base: 32'h100, exp_count: 16, exp_pad: 0};
    fill_line(v);
    held = mk_line(16, 32'h100);
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      s_last  = 1'($urandom_range(0, 1));
      step();
      chk("hold_s_ready", s_ready, 0);
      chk("hold_m_data", m_data, held);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("hold_m_valid", m_valid, 1);
    release_line();

    // Reset after 7 accepts discards the partial line
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h70 + DW'(i);
      step();
    end
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midfill_rst_m_valid", m_valid, 0);
    chk("midfill_rst_count", m_word_count, 0);
    chk("midfill_rst_s_ready", s_ready, 1);
    step();
    rst_n = 1'b1;
    v = '{nwords: 16, last: 1'b1, base: 32'hB0, exp_count: 16, exp_pad: 0};
    fill_line(v);
    release_line();

    // Reset in the middle of padding: no line may appear
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h300 + DW'(i);
      s_last  = (i == 2);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midpad_rst_count", m_word_count, 0);
    step();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      saw |= m_valid;
    end
    chk("midpad_no_m_valid", saw, 0);

    // Random traffic vs line-level model
    closed = 1'b0;
    pad_left = 0;
    lines = 0;
    cyc = 0;
    have_word = 1'b0;
    while (lines < 1000 && cyc < 90000) begin
      exp_valid = closed && (pad_left == 0);
      exp_ready = !closed;
      chk("rnd_s_ready", s_ready, exp_ready);
      chk("rnd_m_valid", m_valid, exp_valid);
      if (!have_word) begin
        word      = $urandom;
        word_last = ($urandom_range(0, 7) == 0);
        have_word = 1'b1;
      end
      s_valid = ($urandom_range(0, 3) != 0);
      if (closed) begin
        s_data = $urandom;
        s_last = 1'($urandom_range(0, 1));
      end else begin
        s_data = word;
        s_last = word_last;
      end
      m_ready = ($urandom_range(0, 2) != 0);
      if (!closed) begin
        if (s_valid) begin
          cur.push_back(word);
          have_word = 1'b0;
          if (word_last || cur.size() == W) begin
            closed   = 1'b1;
            pad_left = W - cur.size();
          end
        end
      end else if (pad_left > 0) begin
        pad_left--;
      end else if (m_ready) begin
        el = '0;
        foreach (cur[i]) el[i*DW +: DW] = cur[i];
        chk("rnd_line", m_data, el);
        chk("rnd_count", m_word_count, cur.size());
        cur.delete();
        closed = 1'b0;
        lines++;
      end
      step();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("rnd_lines_done", lines, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_fill_ctrl.md
LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

Interface
REQ-001: Parameter DATA_WIDTH, default 32, is the width of one input word in bits.
REQ-002: Parameter WORDS_PER_ENTRY, default 16, is the number of words per line (power of two, at least 2).
REQ-003: Port clk, input, 1 bit, is the single clock; all state updates occur on its rising edge.
REQ-004: Port rst_n, input, 1 bit, is the reset: asynchronous and active-low.
REQ-005: Port s_valid, input, 1 bit, is the input word valid flag.
REQ-006: Port s_ready, output, 1 bit, is the input word ready flag.
REQ-007: Port s_data, input, DATA_WIDTH bits, is the input word.
REQ-008: Port s_last, input, 1 bit, marks the final word of a line and is sampled with s_data.
REQ-009: Port m_valid, output, 1 bit, flags that an assembled line is available.
REQ-010: Port m_ready, input, 1 bit, is the consumer's line-accept flag.
REQ-011: Port m_data, output, WORDS_PER_ENTRY*DATA_WIDTH bits, is the line; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012: Port m_word_count, output, $clog2(WORDS_PER_ENTRY)+1 bits, is the number of source words in the line (1..WORDS_PER_ENTRY).

Function
REQ-013: The FSM SHALL have exactly three states: FILL, PAD and FULL.
REQ-014: s_ready SHALL equal (state==FILL), with no combinational path from s_valid or m_ready.
REQ-015: Word accept SHALL occur when s_valid&&s_ready; the word is written at the current index, and the index increments on that edge.
REQ-016: In FILL, an accept at index WORDS_PER_ENTRY-1, or an accept with s_last=1 at index WORDS_PER_ENTRY-1, SHALL move the FSM to FULL on that edge.
REQ-017: In FILL, an accept with s_last=1 at index k<WORDS_PER_ENTRY-1 SHALL move the FSM to PAD with the index set to k+1.
REQ-018: PAD SHALL write zero to one word per cycle at indices k+1..WORDS_PER_ENTRY-1 and SHALL enter FULL on the edge that writes the last index, taking WORDS_PER_ENTRY-1-k cycles.
REQ-019: m_word_count SHALL latch (accepted index + 1) on the accept that ends the source words, whether through s_last or the final index.
REQ-020: m_valid SHALL equal (state==FULL); m_data SHALL be stable, with no writes, while in FULL.
REQ-021: In FULL, m_valid&&m_ready SHALL return the FSM to FILL with the index cleared to 0; s_ready rises on the following cycle.
REQ-022: s_valid in PAD or FULL SHALL be ignored and the input held off; s_data/s_last need not be stable while s_ready=0.
REQ-023: The line SHALL contain words in accept order, word 0 first at the LSBs.
REQ-024: Throughput SHALL be at most one word per cycle; a full line costs WORDS_PER_ENTRY fill cycles plus at least 1 FULL cycle.
REQ-025: m_data SHALL be defined only while m_valid=1; it is X before the first complete line after power-up.

Reset
REQ-026: On assertion of rst_n=0, the FSM SHALL go to FILL, the index to 0 and m_word_count to 0, giving m_valid=0 and s_ready=1.
REQ-027: Reset mid-FILL or mid-PAD SHALL discard the partial line, with no m_valid pulse.
REQ-028: Line storage SHALL NOT be reset.

Structure
REQ-029: Package line_fill_pkg SHALL hold the state enum (FILL, PAD, FULL) and default width constants.
REQ-030: Line storage SHALL be one instance of reg_file_single; the write enable is (accept || state==PAD) and the write data is s_data or 0.
REQ-031: The index counter width SHALL be $clog2(WORDS_PER_ENTRY) and it SHALL wrap only through REQ-021.

Verification (DATA_WIDTH=32, WORDS_PER_ENTRY=16)
REQ-032: Scenario: 16 back-to-back words 0x00..0x0F with s_last on the 16th, m_ready=1 -> m_valid asserts on the cycle after the 16th accept; m_data word i = i; count=16; s_ready=1 one cycle after handoff.
REQ-033: Scenario: 5 words 0xA0..0xA4 with s_last on the 5th -> 11 PAD cycles, then m_valid; words 0..4 = 0xA0..0xA4, words 5..15 = 0; count=5.
REQ-034: Scenario: a full line held with m_ready=0 for 20 cycles while s_valid=1 with new data -> s_ready=0 throughout, m_data unchanged, and the line is delivered intact when m_ready=1.
REQ-035: Scenario: s_last on the 1st word after a prior full line -> words 1..15 = 0 (no stale data); count=1.
REQ-036: Scenario: rst_n pulsed low after 7 accepts -> m_valid and count are 0 immediately; the next 16 words 0xB0..0xBF form a line with word 0 = 0xB0.
REQ-037: Scenario: random s_valid/m_ready gaps across 1000 lines against a reference model -> all lines and counts match and no word is dropped or duplicated.
